// File: rtl/uop_ctrl_sequencer.sv
// Micro-op control sequencer: latches one instruction's packed control ROM line and issues one
// resolved uop per cycle over valid/ready. Define UOP_SEQ_PERF_EN to add perf_uops/perf_stall counters.
module uop_ctrl_sequencer #(
    parameter int NUM_UOPS = 3,
    parameter int OP_W     = 4,
    parameter int CNT_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CNT_W-1:0]             uop_cnt,
    input  logic [2*NUM_UOPS-1:0]        rom_sr_reg,
    input  logic [2*NUM_UOPS-1:0]        rom_sr_mem,
    input  logic [2*NUM_UOPS-1:0]        rom_size,
    input  logic [NUM_UOPS-1:0]          rom_no_over,
    input  logic [3*OP_W*NUM_UOPS-1:0]   rom_alu_op,
    input  logic [1:0]                   mod,
    input  logic                         mod_rm_pr,
    input  logic [2:0]                   reg_op,
    input  logic                         prefix_op_size,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_sr_sel,
    output logic [1:0]                   out_size,
    output logic [OP_W-1:0]              out_alu_op,
    output logic [CNT_W-1:0]             out_idx,
    output logic                         out_last
`ifdef UOP_SEQ_PERF_EN
    ,
    output logic [15:0]                  perf_uops,
    output logic [15:0]                  perf_stall
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_UOPS);

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]             last_idx_q;
    logic [CNT_W-1:0]             eff_cnt;
    logic [2*NUM_UOPS-1:0]        sr_reg_q, sr_mem_q, size_q;
    logic [NUM_UOPS-1:0]          no_over_q;
    logic [3*OP_W*NUM_UOPS-1:0]   alu_op_q;
    logic                         mod_sel_q;
    logic                         prefix_q;
    logic [2:0]                   reg_op_q;
    logic                         fire;
    logic                         accept;
    logic                         grp_s0, grp_s1;
    int                           slot;

    // A zero count still carries one uop; oversize counts are clamped to the line width.
    always_comb begin
        eff_cnt = uop_cnt;
        if (uop_cnt == '0) begin
            eff_cnt = CNT_W'(1);
        end else if (uop_cnt > MAX_CNT) begin
            eff_cnt = MAX_CNT;
        end
    end

    assign out_valid = (state_q == SEQ);
    assign out_last  = out_valid && (idx_q == last_idx_q);
    assign fire      = out_valid && out_ready;
    assign in_ready  = (state_q == IDLE) || (fire && out_last);
    assign accept    = in_valid && in_ready && !flush;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (accept) begin
            state_d = SEQ;
            idx_d   = '0;
        end else if (fire && out_last) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (fire) begin
            idx_d   = idx_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the line buffer carries no reset; it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            sr_reg_q   <= rom_sr_reg;
            sr_mem_q   <= rom_sr_mem;
            size_q     <= rom_size;
            no_over_q  <= rom_no_over;
            alu_op_q   <= rom_alu_op;
            mod_sel_q  <= mod[1] & mod[0] & mod_rm_pr;
            prefix_q   <= prefix_op_size;
            reg_op_q   <= reg_op;
            last_idx_q <= eff_cnt - CNT_W'(1);
        end
    end

    // Group-opcode extension: reg 001/011 pick op2, 100/110 pick op3, anything else op1.
    assign grp_s0 = ~(reg_op_q[2] & reg_op_q[0]) & reg_op_q[0];
    assign grp_s1 = ~(reg_op_q[2] & reg_op_q[0]) & reg_op_q[2];

    always_comb begin
        slot       = int'(idx_q);
        out_sr_sel = '0;
        out_size   = '0;
        out_alu_op = '0;
        out_idx    = '0;
        if (out_valid) begin
            out_idx    = idx_q;
            out_sr_sel = mod_sel_q ? sr_reg_q[2*slot +: 2] : sr_mem_q[2*slot +: 2];
            if (prefix_q && !no_over_q[slot]) begin
                out_size = 2'b01;
            end else begin
                out_size = size_q[2*slot +: 2];
            end
            if (grp_s0) begin
                out_alu_op = alu_op_q[(3*slot+1)*OP_W +: OP_W];
            end else if (grp_s1) begin
                out_alu_op = alu_op_q[(3*slot+2)*OP_W +: OP_W];
            end else begin
                out_alu_op = alu_op_q[(3*slot)*OP_W +: OP_W];
            end
        end
    end

`ifdef UOP_SEQ_PERF_EN
    // Saturating event counters; flush does not disturb them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_uops  <= '0;
            perf_stall <= '0;
        end else begin
            if (fire && perf_uops != 16'hFFFF) begin
                perf_uops <= perf_uops + 16'd1;
            end
            if (out_valid && !out_ready && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uop_ctrl_sequencer.sv
// Self-checking bench for uop_ctrl_sequencer: directed scenarios plus random traffic, scored
// against a transaction-level queue model of expected uops.
module tb_uop_ctrl_sequencer;

    localparam int N     = 3;
    localparam int OP_W  = 4;
    localparam int CNT_W = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [CNT_W-1:0]        uop_cnt;
    logic [2*N-1:0]          rom_sr_reg;
    logic [2*N-1:0]          rom_sr_mem;
    logic [2*N-1:0]          rom_size;
    logic [N-1:0]            rom_no_over;
    logic [3*OP_W*N-1:0]     rom_alu_op;
    logic [1:0]              mod;
    logic                    mod_rm_pr;
    logic [2:0]              reg_op;
    logic                    prefix_op_size;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              out_sr_sel;
    logic [1:0]              out_size;
    logic [OP_W-1:0]         out_alu_op;
    logic [CNT_W-1:0]        out_idx;
    logic                    out_last;
`ifdef UOP_SEQ_PERF_EN
    logic [15:0]             perf_uops;
    logic [15:0]             perf_stall;
`endif

    uop_ctrl_sequencer #(.NUM_UOPS(N), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .uop_cnt        (uop_cnt),
        .rom_sr_reg     (rom_sr_reg),
        .rom_sr_mem     (rom_sr_mem),
        .rom_size       (rom_size),
        .rom_no_over    (rom_no_over),
        .rom_alu_op     (rom_alu_op),
        .mod            (mod),
        .mod_rm_pr      (mod_rm_pr),
        .reg_op         (reg_op),
        .prefix_op_size (prefix_op_size),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sr_sel     (out_sr_sel),
        .out_size       (out_size),
        .out_alu_op     (out_alu_op),
        .out_idx        (out_idx),
        .out_last       (out_last)
`ifdef UOP_SEQ_PERF_EN
        ,
        .perf_uops      (perf_uops),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      sr;
        logic [1:0]      size;
        logic [OP_W-1:0] alu;
        int              idx;
        bit              last;
    } uop_t;

    uop_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_uops  = 0;
    int   exp_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected uop list for the instruction currently on the inputs.
    function automatic void push_instr();
        int   eff;
        int   grp;
        uop_t u;
        if (uop_cnt == 0) eff = 1;
        else if (int'(uop_cnt) > N) eff = N;
        else eff = int'(uop_cnt);
        case (reg_op)
            3'd1, 3'd3: grp = 1;
            3'd4, 3'd6: grp = 2;
            default:    grp = 0;
        endcase
        for (int i = 0; i < eff; i++) begin
            u.sr   = (mod == 2'b11 && mod_rm_pr) ? rom_sr_reg[2*i +: 2] : rom_sr_mem[2*i +: 2];
            u.size = (prefix_op_size && !rom_no_over[i]) ? 2'b01 : rom_size[2*i +: 2];
            u.alu  = rom_alu_op[(3*i+grp)*OP_W +: OP_W];
            u.idx  = i;
            u.last = (i == eff - 1);
            exp_q.push_back(u);
        end
    endfunction

    task automatic rand_line();
        uop_cnt        = CNT_W'($urandom);
        rom_sr_reg     = (2*N)'($urandom);
        rom_sr_mem     = (2*N)'($urandom);
        rom_size       = (2*N)'($urandom);
        rom_no_over    = N'($urandom);
        rom_alu_op     = (3*OP_W*N)'({$urandom, $urandom});
        mod            = 2'($urandom);
        mod_rm_pr      = 1'($urandom);
        reg_op         = 3'($urandom);
        prefix_op_size = 1'($urandom);
    endtask

    // Called just after a falling edge with inputs settled: check, clock, advance the model.
    task automatic cycle();
        bit ev;
        bit er;
        #1;
        ev = (exp_q.size() > 0);
        er = !ev || (out_ready && exp_q.size() == 1);
        check("out_valid", 32'(out_valid), 32'(ev));
        check("in_ready", 32'(in_ready), 32'(er));
        if (ev) begin
            check("out_sr_sel", 32'(out_sr_sel), 32'(exp_q[0].sr));
            check("out_size", 32'(out_size), 32'(exp_q[0].size));
            check("out_alu_op", 32'(out_alu_op), 32'(exp_q[0].alu));
            check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            check("out_last", 32'(out_last), 32'(exp_q[0].last));
        end
`ifdef UOP_SEQ_PERF_EN
        check("perf_uops", 32'(perf_uops), 32'(exp_uops));
        check("perf_stall", 32'(perf_stall), 32'(exp_stall));
`endif
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_uops  = 0;
            exp_stall = 0;
        end else begin
            if (ev && out_ready && exp_uops < 65535) exp_uops++;
            if (ev && !out_ready && exp_stall < 65535) exp_stall++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (ev && out_ready) void'(exp_q.pop_front());
                if (in_valid && er) push_instr();
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic issue_and_drain(input int cycles);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    initial begin
        quiet();
        rand_line();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_sr_sel", 32'(out_sr_sel), 32'd0);
        check("rst_out_size", 32'(out_size), 32'd0);
        check("rst_out_alu_op", 32'(out_alu_op), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Three uops, register operand form.
        rand_line();
        uop_cnt = 2'd3; mod = 2'b11; mod_rm_pr = 1'b1;
        issue_and_drain(4);

        // Operand-size override with a per-slot opt-out.
        rand_line();
        uop_cnt = 2'd2; prefix_op_size = 1'b1; rom_size = 6'b10_10_10; rom_no_over = 3'b010;
        issue_and_drain(3);

        // Group-opcode selection.
        for (int k = 0; k < 4; k++) begin
            logic [2:0] ops [4] = '{3'b001, 3'b100, 3'b101, 3'b000};
            rand_line();
            uop_cnt = 2'd1;
            reg_op  = ops[k];
            issue_and_drain(2);
        end

        // Four-cycle stall at slot 1.
        rand_line();
        uop_cnt = 2'd3;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        repeat (4) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // Back-to-back single-uop instructions.
        for (int k = 0; k < 3; k++) begin
            rand_line();
            uop_cnt  = 2'd1;
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // Flush at slot 1 with a competing accept, then a zero-count line.
        rand_line();
        uop_cnt = 2'd3;
        issue_and_drain(1);
        rand_line();
        flush = 1'b1; in_valid = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        rand_line();
        uop_cnt = 2'd0;
        issue_and_drain(3);

        // Reset in the middle of a sequence.
        rand_line();
        uop_cnt = 2'd3;
        issue_and_drain(1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rand_line();
            in_valid  = ($urandom_range(0, 99) < 55);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 5);
            rst       = ($urandom_range(0, 199) < 1);
            cycle();
        end
        quiet();
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
